// File: rtl/q2_lcd.sv
// q2_lcd: memory-mapped HD44780-style LCD write port plus debounced keypad
// read port for the q2 CPU bus. CPU writes are queued in a small FIFO and
// played out with enable-pulse and settle timing after a fixed init sequence.

// One debounced key bit: the output follows the synchronised input only after
// DB_CYCLES consecutive samples that differ from the current output.
module q2_lcd_key_lane #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_s,
  output logic key_db
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt;

  // Count agreeing-but-different samples; any sample equal to the current
  // output is a glitch back and restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      key_db <= 1'b1;
    end else if (key_s == key_db) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      key_db <= key_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module q2_lcd #(
  parameter logic [11:0] IO_ADDR   = 12'hFFF,
  parameter int          E_CYCLES  = 2,
  parameter int          CMD_WAIT  = 4,
  parameter int          CLR_WAIT  = 100,
  parameter int          INIT_WAIT = 200,
  parameter int          DB_CYCLES = 4,
  parameter int          FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  input  logic [11:0] dbus_in,
  input  logic        wrm,
  input  logic        rdm,
  output logic [11:0] dbus_out,
  output logic        dbus_oe,
  input  logic [3:0]  key_n,
  output logic        lcd_rs,
  output logic        lcd_e,
  output logic [7:0]  lcd_d,
  output logic        busy,
  output logic        overflow
);
  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 1 << FIFO_LOG2;

  typedef enum logic [2:0] {INIT_DLY, INIT_CMD, IDLE, SETUP, PULSE, SETTLE} state_t;

  // ---------------- keypad ----------------
  logic [NUM_LANES-1:0] key_s1, key_s2, key_db;

  // Two-flop synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_key
    q2_lcd_key_lane #(.DB_CYCLES(DB_CYCLES)) u_key (
      .clk    (clk),
      .rst    (rst),
      .key_s  (key_s2[gi]),
      .key_db (key_db[gi])
    );
  end

  assign dbus_out = {8'hFF, key_db};
  assign dbus_oe  = rdm && (abus == IO_ADDR);

  // ---------------- write capture + FIFO ----------------
  logic                 wrm_q;
  logic [8:0]           fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]   fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 push_req, push_ok, pop;
  logic [8:0]           wr_entry;
  logic                 unused_dbus;
  state_t               state;

  // Count never exceeds DEPTH, so its top bit alone means full.
  assign fifo_full  = fifo_cnt[FIFO_LOG2];
  assign fifo_empty = (fifo_cnt == '0);
  assign push_req   = wrm && !wrm_q && (abus == IO_ADDR);
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = push_req && (!fifo_full || pop);
  // Entry is {RS, D}: bit8 clear means character data (RS=1).
  assign wr_entry   = {~dbus_in[8], dbus_in[7:0]};
  assign unused_dbus = ^dbus_in[11:9];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy, strobe edge detect and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrm_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wrm_q <= wrm;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // ---------------- LCD sequencer ----------------
  logic [15:0] cnt;
  logic [15:0] settle_last;
  logic [1:0]  init_idx;
  logic        in_init;
  logic        cur_rs;
  logic [7:0]  cur_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;  // 8-bit, 2 lines, 5x8
      2'd1:    return 8'h0C;  // display on, cursor off
      2'd2:    return 8'h06;  // increment, no shift
      default: return 8'h01;  // clear
    endcase
  endfunction

  // Clear and home need the long settle; everything else the short one.
  assign settle_last = (!cur_rs && (cur_d == 8'h01 || cur_d == 8'h02)) ?
                       16'(CLR_WAIT - 1) : 16'(CMD_WAIT - 1);

  assign busy = in_init || fifo_full;

  // Transfer sequencer: outputs are registered and follow the state by one
  // clock, so SETUP presents RS/D and PULSE raises E on its first edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_DLY;
      cnt      <= '0;
      in_init  <= 1'b1;
      init_idx <= '0;
      cur_rs   <= 1'b0;
      cur_d    <= '0;
      lcd_rs   <= 1'b0;
      lcd_d    <= '0;
      lcd_e    <= 1'b0;
    end else begin
      case (state)
        INIT_DLY: begin
          if (cnt == 16'(INIT_WAIT - 1)) begin
            cnt   <= '0;
            state <= INIT_CMD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        INIT_CMD: begin
          cur_rs   <= 1'b0;
          cur_d    <= init_cmd(init_idx);
          init_idx <= init_idx + 2'd1;  // wraps to 0 after the last command
          state    <= SETUP;
        end
        IDLE: begin
          if (!fifo_empty) begin
            {cur_rs, cur_d} <= fifo_mem[rd_ptr];
            state           <= SETUP;
          end
        end
        SETUP: begin
          lcd_rs <= cur_rs;
          lcd_d  <= cur_d;
          lcd_e  <= 1'b0;
          cnt    <= '0;
          state  <= PULSE;
        end
        PULSE: begin
          lcd_e <= 1'b1;
          if (cnt == 16'(E_CYCLES - 1)) begin
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SETTLE: begin
          lcd_e <= 1'b0;
          if (cnt == settle_last) begin
            cnt <= '0;
            if (in_init && init_idx != 2'd0) begin
              state <= INIT_CMD;
            end else begin
              in_init <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= INIT_DLY;
      endcase
    end
  end
endmodule

// File: tb/tb_q2_lcd.sv
// tb_q2_lcd: directed self-checking bench for q2_lcd. A passive monitor logs
// every enable pulse (RS/D at the rising edge, edge number, high length and
// the preceding low length); scenario tasks compare against hand values.
module tb_q2_lcd;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] abus, dbus_in;
  logic        wrm, rdm;
  logic [11:0] dbus_out;
  logic        dbus_oe;
  logic [3:0]  key_n;
  logic        lcd_rs, lcd_e;
  logic [7:0]  lcd_d;
  logic        busy, overflow;

  int tests = 0;
  int fails = 0;

  q2_lcd dut (
    .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in), .wrm(wrm), .rdm(rdm),
    .dbus_out(dbus_out), .dbus_oe(dbus_oe), .key_n(key_n),
    .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  int         edge_cnt = 0;
  logic       e_prev   = 1'b0;
  int         hi_run   = 0;
  int         lo_run   = 0;
  int         stab_err = 0;
  logic [8:0] log_rsd[$];
  int         log_rise[$];
  int         log_gap[$];
  int         log_hi[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (lcd_e) begin
      if (!e_prev) begin
        log_rsd.push_back({lcd_rs, lcd_d});
        log_rise.push_back(edge_cnt);
        log_gap.push_back(lo_run);
        hi_run = 0;
      end else if ({lcd_rs, lcd_d} != log_rsd[$]) begin
        stab_err++;
      end
      hi_run++;
    end else begin
      if (e_prev) begin
        log_hi.push_back(hi_run);
        lo_run = 0;
      end
      lo_run++;
    end
    e_prev = lcd_e;
  end

  // ---------------- drivers (all start/end #1 after a rising edge) --------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [11:0] addr, input logic [11:0] data);
    abus = addr; dbus_in = data; wrm = 1'b1;
    tick(1);
    wrm = 1'b0; abus = 12'h000;
    tick(1);
  endtask

  task automatic wait_rises(input int target, input int limit, output bit ok);
    int k = 0;
    while (log_rise.size() < target && k < limit) begin
      tick(1);
      k++;
    end
    ok = (log_rise.size() >= target);
  endtask

  task automatic wait_falls(input int target, input int limit, output bit ok);
    int k = 0;
    while (log_hi.size() < target && k < limit) begin
      tick(1);
      k++;
    end
    ok = (log_hi.size() >= target);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; wrm = 1'b0; rdm = 1'b0; abus = '0; dbus_in = '0; key_n = 4'hF;
    @(posedge clk); #1;
    tick(2);
    tests++; if (lcd_e !== 1'b0) begin fails++; $display("FAIL reset_lcd_e got %b want 0", lcd_e); end
    tests++; if (lcd_rs !== 1'b0) begin fails++; $display("FAIL reset_lcd_rs got %b want 0", lcd_rs); end
    tests++; if (lcd_d !== 8'h00) begin fails++; $display("FAIL reset_lcd_d got %h want 00", lcd_d); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %b want 1", busy); end
    rdm = 1'b1; abus = 12'hFFF; #1;
    tests++; if (dbus_out !== 12'hFFF) begin fails++; $display("FAIL reset_dbus_out got %h want FFF", dbus_out); end
    tests++; if (dbus_oe !== 1'b1) begin fails++; $display("FAIL reset_dbus_oe got %b want 1", dbus_oe); end
    rdm = 1'b0; abus = '0;
  endtask

  task automatic test_init();
    logic [8:0] exp_rsd [5] = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h15A};
    int  rel, b, hb;
    bit  ok;
    b = log_rise.size(); hb = log_hi.size();
    rst = 1'b0; rel = edge_cnt;
    tick(10);
    cpu_write(12'hFFF, 12'h05A);  // queued during the init delay
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL init_busy got %b want 1", busy); end
    wait_rises(b + 5, 700, ok);
    tests++; if (!ok) begin fails++; $display("FAIL init_timeout got %0d pulses want %0d", log_rise.size() - b, 5); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (log_rsd[b+i] !== exp_rsd[i]) begin
        fails++; $display("FAIL init_rsd[%0d] got %h want %h", i, log_rsd[b+i], exp_rsd[i]);
      end
    end
    tests++;
    if (log_rise[b] - rel != 203) begin
      fails++; $display("FAIL init_first_edge got %0d want 203", log_rise[b] - rel);
    end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (log_gap[b+i] != 6) begin fails++; $display("FAIL init_gap[%0d] got %0d want 6", i, log_gap[b+i]); end
    end
    tests++; if (log_gap[b+4] != 102) begin fails++; $display("FAIL init_clr_gap got %0d want 102", log_gap[b+4]); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (log_hi[hb+i] != 2) begin fails++; $display("FAIL init_e_len[%0d] got %0d want 2", i, log_hi[hb+i]); end
    end
    wait_falls(hb + 5, 50, ok);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL init_busy_drop got %b want 0", busy); end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL init_stable got %0d want 0", stab_err); end
  endtask

  task automatic test_single_write();
    int b, hb, n;
    tick(20);
    b = log_rise.size(); hb = log_hi.size();
    abus = 12'hFFF; dbus_in = 12'h041; wrm = 1'b1;
    n = edge_cnt + 1;  // capture edge N
    tick(3);           // strobe held across edges N, N+1, N+2
    wrm = 1'b0; abus = '0;
    tests++;
    if ({lcd_e, lcd_rs, lcd_d} !== {1'b0, 1'b1, 8'h41}) begin
      fails++; $display("FAIL single_setup got e=%b rs=%b d=%h want e=0 rs=1 d=41", lcd_e, lcd_rs, lcd_d);
    end
    tick(30);
    tests++; if (log_rise.size() - b != 1) begin fails++; $display("FAIL single_count got %0d want 1", log_rise.size() - b); end
    tests++; if (log_rsd[b] !== 9'h141) begin fails++; $display("FAIL single_rsd got %h want 141", log_rsd[b]); end
    tests++; if (log_rise[b] != n + 3) begin fails++; $display("FAIL single_e_edge got %0d want %0d", log_rise[b], n + 3); end
    tests++; if (log_hi[hb] != 2) begin fails++; $display("FAIL single_e_len got %0d want 2", log_hi[hb]); end
  endtask

  task automatic test_back_to_back();
    int b;
    bit ok;
    b = log_rise.size();
    cpu_write(12'hFFF, 12'h1C0);
    cpu_write(12'hFFF, 12'h101);
    wait_rises(b + 2, 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout got %0d pulses want 2", log_rise.size() - b); end
    tests++; if (log_rsd[b] !== 9'h0C0) begin fails++; $display("FAIL b2b_rsd0 got %h want 0C0", log_rsd[b]); end
    tests++; if (log_rsd[b+1] !== 9'h001) begin fails++; $display("FAIL b2b_rsd1 got %h want 001", log_rsd[b+1]); end
    tests++; if (log_gap[b+1] != 6) begin fails++; $display("FAIL b2b_gap got %0d want 6", log_gap[b+1]); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    tick(120);
  endtask

  task automatic test_bad_addr();
    int b;
    bit ok;
    b = log_rise.size();
    cpu_write(12'hFFE, 12'h040);
    tick(30);
    tests++; if (log_rise.size() != b) begin fails++; $display("FAIL bad_addr_pulses got %0d want 0", log_rise.size() - b); end
    rdm = 1'b1; abus = 12'hFFE; #1;
    tests++; if (dbus_oe !== 1'b0) begin fails++; $display("FAIL bad_addr_oe got %b want 0", dbus_oe); end
    rdm = 1'b0; abus = '0;
    tick(1);
    cpu_write(12'hFFF, 12'h030);  // first entry out must be this one
    wait_rises(b + 1, 50, ok);
    tests++; if (log_rsd[b] !== 9'h130) begin fails++; $display("FAIL bad_addr_fifo got %h want 130", log_rsd[b]); end
    tick(20);
  endtask

  task automatic test_keys();
    rdm = 1'b1; abus = 12'hFFF;
    key_n = 4'b1011;
    tick(5);
    tests++; if (dbus_out !== 12'hFFF) begin fails++; $display("FAIL key_early got %h want FFF", dbus_out); end
    tick(1);
    tests++; if (dbus_out !== 12'hFFB) begin fails++; $display("FAIL key_press got %h want FFB", dbus_out); end
    tests++; if (dbus_oe !== 1'b1) begin fails++; $display("FAIL key_oe got %b want 1", dbus_oe); end
    key_n = 4'b1111;
    tick(2);
    key_n = 4'b1011;
    tick(10);
    tests++; if (dbus_out !== 12'hFFB) begin fails++; $display("FAIL key_glitch got %h want FFB", dbus_out); end
    key_n = 4'b1111;
    tick(6);
    tests++; if (dbus_out !== 12'hFFF) begin fails++; $display("FAIL key_release got %h want FFF", dbus_out); end
    rdm = 1'b0; abus = '0;
  endtask

  task automatic test_overflow();
    int b, hb;
    bit ok;
    b = log_rise.size(); hb = log_hi.size();
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_pre got %b want 0", overflow); end
    cpu_write(12'hFFF, 12'h101);
    wait_falls(hb + 1, 50, ok);  // now inside the clear settle
    for (int i = 0; i < 6; i++) begin
      cpu_write(12'hFFF, 12'h061 + 12'(i));
      if (i == 3) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovf_busy_full got %b want 1", busy); end
      end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovf_busy got %b want 1", busy); end
    wait_rises(b + 5, 300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout got %0d pulses want 5", log_rise.size() - b); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (log_rsd[b+1+i] !== 9'h161 + 9'(i)) begin
        fails++; $display("FAIL ovf_rsd[%0d] got %h want %h", i, log_rsd[b+1+i], 9'h161 + 9'(i));
      end
    end
    tests++; if (log_gap[b+1] != 102) begin fails++; $display("FAIL ovf_clr_gap got %0d want 102", log_gap[b+1]); end
    tick(50);
    tests++; if (log_rise.size() - b != 5) begin fails++; $display("FAIL ovf_count got %0d want 5", log_rise.size() - b); end
  endtask

  task automatic test_rst_mid();
    int  b, rel, k;
    bit  ok;
    cpu_write(12'hFFF, 12'h048);
    cpu_write(12'hFFF, 12'h049);
    k = 0;
    while (lcd_e !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    tests++; if (lcd_e !== 1'b1) begin fails++; $display("FAIL rstmid_pulse got %b want 1", lcd_e); end
    rst = 1'b1;
    tick(1);
    tests++; if (lcd_e !== 1'b0) begin fails++; $display("FAIL rstmid_e got %b want 0", lcd_e); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy got %b want 1", busy); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    b = log_rise.size();
    rst = 1'b0; rel = edge_cnt;
    wait_rises(b + 4, 700, ok);
    tests++; if (log_rsd[b] !== 9'h038) begin fails++; $display("FAIL rstmid_first got %h want 038", log_rsd[b]); end
    tests++; if (log_rise[b] - rel != 203) begin fails++; $display("FAIL rstmid_edge got %0d want 203", log_rise[b] - rel); end
    tests++; if (log_rsd[b+3] !== 9'h001) begin fails++; $display("FAIL rstmid_last got %h want 001", log_rsd[b+3]); end
    tick(150);
    tests++; if (log_rise.size() - b != 4) begin fails++; $display("FAIL rstmid_flush got %0d want 4", log_rise.size() - b); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_back_to_back();
    test_bad_addr();
    test_keys();
    test_overflow();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
